// File: rtl/adc_spi_sampler.sv
`timescale 1ns/1ps
// adc_spi_sampler
// Periodically reads one conversion from an MCP3201-style SPI ADC (mode 0,
// read-only). The result goes out on o_temp_NEW with a one-cycle o_SAMPLE
// strobe. Sample-rate overruns and malformed frames are flagged.
//
// Ports:
//   i_CLK        system clock, rising edge
//   i_RESET      asynchronous active-high reset
//   i_ENABLE     level, runs the sample-rate timer
//   i_MISO       ADC serial data (already synchronised)
//   o_CS_N       ADC chip select, active low
//   o_SCLK       SPI clock, idle low
//   o_temp_NEW   last valid conversion, held between strobes
//   o_SAMPLE     one-cycle strobe, o_temp_NEW updated this cycle
//   o_OVERRUN    sticky, request tick arrived while a frame was busy
//   o_FRAME_ERR  one-cycle pulse, frame discarded (null bit was 1)
module adc_spi_sampler #(
   parameter int unsigned CLK_DIV       = 4,
   parameter int unsigned SAMPLE_PERIOD = 256,
   parameter int unsigned DATA_W        = 12
) (
   input  logic              i_CLK,
   input  logic              i_RESET,
   input  logic              i_ENABLE,
   input  logic              i_MISO,
   output logic              o_CS_N,
   output logic              o_SCLK,
   output logic [DATA_W-1:0] o_temp_NEW,
   output logic              o_SAMPLE,
   output logic              o_OVERRUN,
   output logic              o_FRAME_ERR
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TMR_W = $clog2(SAMPLE_PERIOD);
   // Null bit plus data bits; older bits fall off the top.
   localparam int unsigned SH_W  = DATA_W + 1;
   localparam logic [3:0]  LAST_BIT = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_HOLD    = 3'd3,
      ST_PUBLISH = 3'd4
   } state_t;

   state_t            state;
   logic              en_q;
   logic [TMR_W-1:0]  tmr;
   logic [DIV_W-1:0]  div_cnt;
   logic [3:0]        bit_cnt;
   logic              phase_hi;
   logic [SH_W-1:0]   shreg;
   logic              tick_c;
   logic              div_last_c;

   // Request tick: last count of the rate timer while enabled.
   assign tick_c     = en_q && (tmr == TMR_W'(SAMPLE_PERIOD - 1));
   assign div_last_c = (div_cnt == DIV_W'(CLK_DIV - 1));

   // Sample-rate timer, driven from the registered enable.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         en_q <= 1'b0;
         tmr  <= '0;
      end else begin
         en_q <= i_ENABLE;
         if (!en_q || tick_c)
            tmr <= '0;
         else
            tmr <= tmr + TMR_W'(1);
      end
   end

   // Frame sequencer with registered SPI and result outputs.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         state       <= ST_IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         phase_hi    <= 1'b0;
         shreg       <= '0;
         o_CS_N      <= 1'b1;
         o_SCLK      <= 1'b0;
         o_temp_NEW  <= '0;
         o_SAMPLE    <= 1'b0;
         o_OVERRUN   <= 1'b0;
         o_FRAME_ERR <= 1'b0;
      end else begin
         o_SAMPLE    <= 1'b0;
         o_FRAME_ERR <= 1'b0;

         // Any tick outside IDLE (PUBLISH included) is dropped.
         if (tick_c && (state != ST_IDLE))
            o_OVERRUN <= 1'b1;

         case (state)
            ST_IDLE: begin
               o_CS_N <= 1'b1;
               o_SCLK <= 1'b0;
               if (tick_c) begin
                  state   <= ST_SETUP;
                  o_CS_N  <= 1'b0;
                  div_cnt <= '0;
               end
            end

            ST_SETUP: begin
               if (div_last_c) begin
                  state    <= ST_SHIFT;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  phase_hi <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            ST_SHIFT: begin
               if (div_last_c) begin
                  div_cnt <= '0;
                  if (!phase_hi) begin
                     // Rising SCLK edge: capture MISO; bit 15 is not kept.
                     o_SCLK   <= 1'b1;
                     phase_hi <= 1'b1;
                     if (bit_cnt != LAST_BIT)
                        shreg <= {shreg[SH_W-2:0], i_MISO};
                  end else begin
                     o_SCLK   <= 1'b0;
                     phase_hi <= 1'b0;
                     if (bit_cnt == LAST_BIT) begin
                        o_CS_N <= 1'b1;
                        state  <= ST_HOLD;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            ST_HOLD: begin
               if (div_last_c) begin
                  state   <= ST_PUBLISH;
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            ST_PUBLISH: begin
               // shreg[DATA_W] is the null bit, below it the data MSB first.
               if (shreg[DATA_W]) begin
                  o_FRAME_ERR <= 1'b1;
               end else begin
                  o_temp_NEW <= shreg[DATA_W-1:0];
                  o_SAMPLE   <= 1'b1;
               end
               state <= ST_IDLE;
            end

            default: begin
               state  <= ST_IDLE;
               o_CS_N <= 1'b1;
               o_SCLK <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_sampler.sv
`timescale 1ns/1ps
// Directed bench for adc_spi_sampler: unit A (CLK_DIV=2, SAMPLE_PERIOD=80)
// exercises data path, framing error, enable drop and async reset; unit B
// (CLK_DIV=2, SAMPLE_PERIOD=40) exercises overrun. Cycle 0 is the cycle in
// which i_ENABLE is raised (it is sampled at the end of that cycle).
module tb_adc_spi_sampler;

   logic        clk;
   logic        rst_a, en_a, miso_a, cs_n_a, sclk_a, sample_a, ovr_a, ferr_a;
   logic [11:0] temp_a;
   logic        rst_b, en_b, miso_b, cs_n_b, sclk_b, sample_b, ovr_b, ferr_b;
   logic [11:0] temp_b;

   int          n_vec;
   int          n_err;
   int          cyc;
   int          base;

   // ADC model state
   logic        nb_a;
   logic [11:0] word_a;
   logic [11:0] word_b;
   logic [15:0] frm_a;
   logic [15:0] frm_b;
   int          idx_a;
   int          idx_b;

   // Monitors
   int          rises_a;
   int          hi_a;
   int          falls_a;

   adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(80), .DATA_W(12)) u_dut_a (
      .i_CLK       (clk),
      .i_RESET     (rst_a),
      .i_ENABLE    (en_a),
      .i_MISO      (miso_a),
      .o_CS_N      (cs_n_a),
      .o_SCLK      (sclk_a),
      .o_temp_NEW  (temp_a),
      .o_SAMPLE    (sample_a),
      .o_OVERRUN   (ovr_a),
      .o_FRAME_ERR (ferr_a)
   );

   adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(40), .DATA_W(12)) u_dut_b (
      .i_CLK       (clk),
      .i_RESET     (rst_b),
      .i_ENABLE    (en_b),
      .i_MISO      (miso_b),
      .o_CS_N      (cs_n_b),
      .o_SCLK      (sclk_b),
      .o_temp_NEW  (temp_b),
      .o_SAMPLE    (sample_b),
      .o_OVERRUN   (ovr_b),
      .o_FRAME_ERR (ferr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame bit 0 is sent first: two ignored bits (driven 1), null bit,
   // 12 data bits MSB first, one trailing ignored bit (driven 1).
   function automatic logic [15:0] mk_frame(input logic nb, input logic [11:0] d);
      return {2'b11, nb, d, 1'b1};
   endfunction

   // ADC A: first bit valid at CS fall, next bit after each SCLK fall.
   always @(negedge cs_n_a) begin
      idx_a  = 0;
      frm_a  = mk_frame(nb_a, word_a);
      miso_a = frm_a[15];
   end
   always @(negedge sclk_a) begin
      if (!cs_n_a && idx_a < 15) begin
         idx_a  = idx_a + 1;
         miso_a = frm_a[4'(15 - idx_a)];
      end
   end

   // ADC B: same model, always a good frame.
   always @(negedge cs_n_b) begin
      idx_b  = 0;
      frm_b  = mk_frame(1'b0, word_b);
      miso_b = frm_b[15];
   end
   always @(negedge sclk_b) begin
      if (!cs_n_b && idx_b < 15) begin
         idx_b  = idx_b + 1;
         miso_b = frm_b[4'(15 - idx_b)];
      end
   end

   always @(posedge sclk_a) rises_a = rises_a + 1;
   always @(negedge clk) if (sclk_a === 1'b1) hi_a = hi_a + 1;
   always @(negedge cs_n_a) falls_a = falls_a + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec = n_vec + 1;
      assert (obs === expv)
      else begin
         n_err = n_err + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance to the falling edge inside cycle c.
   task automatic goto(input int c);
      while (cyc < c) begin
         @(negedge clk);
         cyc = cyc + 1;
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      cyc     = 0;
      base    = 0;
      rises_a = 0;
      hi_a    = 0;
      falls_a = 0;
      idx_a   = 0;
      idx_b   = 0;
      frm_a   = '0;
      frm_b   = '0;
      miso_a  = 1'b0;
      miso_b  = 1'b0;
      rst_a   = 1'b1;
      rst_b   = 1'b1;
      en_a    = 1'b0;
      en_b    = 1'b0;
      nb_a    = 1'b0;
      word_a  = 12'hA5C;
      word_b  = 12'h3C5;

      repeat (3) @(negedge clk);
      chk("rst_cs_n",   32'(cs_n_a),   32'h1);
      chk("rst_sclk",   32'(sclk_a),   32'h0);
      chk("rst_temp",   32'(temp_a),   32'h0);
      chk("rst_sample", 32'(sample_a), 32'h0);
      chk("rst_ovr",    32'(ovr_a),    32'h0);
      chk("rst_ferr",   32'(ferr_a),   32'h0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      @(negedge clk);
      en_a = 1'b1;
      en_b = 1'b1;
      cyc  = 0;

      // First tick at 80, CS falls at 81; B overruns on its second tick.
      goto(80);
      chk("a_cs_before_tick", 32'(cs_n_a), 32'h1);
      chk("b_ovr_before",     32'(ovr_b),  32'h0);
      rises_a = 0;
      hi_a    = 0;
      goto(81);
      chk("a_cs_fall_81", 32'(cs_n_a), 32'h0);
      chk("b_ovr_set",    32'(ovr_b),  32'h1);

      goto(110);
      chk("b_sample_110", 32'(sample_b), 32'h1);
      chk("b_temp_110",   32'(temp_b),   32'h3C5);

      // Strobe at tick + 70.
      goto(149);
      chk("a_sample_149", 32'(sample_a), 32'h0);
      goto(150);
      chk("a_sample_150", 32'(sample_a), 32'h1);
      chk("a_temp_a5c",   32'(temp_a),   32'hA5C);
      goto(151);
      chk("a_sample_151", 32'(sample_a), 32'h0);
      chk("a_cs_idle",    32'(cs_n_a),   32'h1);
      chk("a_sclk_rises", 32'(rises_a),  32'd16);
      chk("a_sclk_hi",    32'(hi_a),     32'd32);
      word_a = 12'hFFF;

      goto(190);
      chk("b_sample_190", 32'(sample_b), 32'h1);

      goto(229);
      chk("a_temp_hold", 32'(temp_a), 32'hA5C);
      goto(230);
      chk("a_sample_230", 32'(sample_a), 32'h1);
      chk("a_temp_fff",   32'(temp_a),   32'hFFF);
      goto(231);
      word_a = 12'h000;

      goto(270);
      chk("b_sample_270", 32'(sample_b), 32'h1);
      chk("b_ovr_sticky", 32'(ovr_b),    32'h1);

      goto(310);
      chk("a_sample_310", 32'(sample_a), 32'h1);
      chk("a_temp_000",   32'(temp_a),   32'h000);
      goto(311);
      word_a = 12'h001;

      goto(390);
      chk("a_temp_001", 32'(temp_a), 32'h001);
      chk("a_no_ovr",   32'(ovr_a),  32'h0);
      goto(391);
      word_a = 12'h456;

      goto(470);
      chk("a_temp_456", 32'(temp_a), 32'h456);
      goto(471);
      nb_a   = 1'b1;
      word_a = 12'h123;

      // Null bit 1: error pulse, no strobe, value held.
      goto(550);
      chk("a_ferr_550",   32'(ferr_a),   32'h1);
      chk("a_nosamp_550", 32'(sample_a), 32'h0);
      chk("a_temp_kept",  32'(temp_a),   32'h456);
      goto(551);
      chk("a_ferr_551", 32'(ferr_a), 32'h0);
      nb_a   = 1'b0;
      word_a = 12'h7E1;

      // Enable dropped while in SETUP; frame still completes.
      goto(561);
      chk("a_cs_setup", 32'(cs_n_a), 32'h0);
      en_a = 1'b0;
      goto(630);
      chk("a_sample_630", 32'(sample_a), 32'h1);
      chk("a_temp_7e1",   32'(temp_a),   32'h7E1);
      goto(631);
      falls_a = 0;
      goto(1131);
      chk("a_quiet_cs", 32'(falls_a), 32'd0);

      // Re-enable, then async reset during bit 7 high phase (tick+33..34).
      en_a = 1'b1;
      base = cyc;
      goto(base + 113);
      chk("a_bit7_sclk", 32'(sclk_a), 32'h1);
      #1 rst_a = 1'b1;
      #1;
      chk("a_arst_cs_n", 32'(cs_n_a), 32'h1);
      chk("a_arst_sclk", 32'(sclk_a), 32'h0);
      chk("a_arst_temp", 32'(temp_a), 32'h0);
      rst_a = 1'b0;

      base = cyc;
      goto(base + 80);
      chk("a_post_rst_cs_80", 32'(cs_n_a), 32'h1);
      goto(base + 81);
      chk("a_post_rst_cs_81", 32'(cs_n_a), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
